axi_lite_io_slave: RTL and testbench

- AXI4-Lite responder that terminates single-beat reads and writes from an external master.
- Serializes them onto the simple internal IO register bus (io_write_en/io_read_en/io_address/io_write_data/io_read_data) that peripherals such as the UART, timer and GPIO hang off.
- Counterpart of the core-side IO master bridge: that bridge issues AXI-Lite; this block answers it and drives the peripherals.
- One transaction in flight at a time; AW and W channels are captured independently.

---
 rtl/axi_lite_io_slave_pkg.sv | 36 +++
 rtl/axi_lite_hold_reg.sv | 48 ++++
 rtl/axi_lite_io_slave.sv | 219 +++++++++++++++++++++
 tb/tb_axi_lite_io_slave.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_io_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_io_slave_pkg
// Description : Shared types for the AXI4-Lite to IO-bus responder: the AXI
//               response code enum, the slave state encoding and a helper
//               that turns decode results into a response code.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_lite_io_slave_pkg;

   localparam int IO_WIDTH = 32;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } axi_resp_t;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WR_ISSUE   = 3'd1,
      ST_RD_ISSUE   = 3'd2,
      ST_RD_CAPTURE = 3'd3,
      ST_B_RESP     = 3'd4,
      ST_R_RESP     = 3'd5
   } slave_state_t;

   // An address miss outranks a partial-strobe error.
   function automatic axi_resp_t decode_resp(input logic hit, input logic strb_full);
      if (!hit)       return DECERR;
      if (!strb_full) return SLVERR;
      return OKAY;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_hold_reg.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_hold_reg
// Description : One-deep holding register for a single AXI channel. Accepts a
//               beat whenever empty and keeps it until the owning transaction
//               completes and clear is pulsed.
// Ports       : clk, reset     - clock, synchronous active-high reset
//               in_valid/in_ready/in_data - upstream valid/ready channel
//               clear          - release the held beat
//               full, data     - held-beat flag and payload
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_hold_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             clear,
   output logic             full,
   output logic [WIDTH-1:0] data
);

   logic             r_full;
   logic [WIDTH-1:0] r_data;

   // clear is only ever raised while full, and capture only happens while
   // empty, so the two branches never compete for the same beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_full <= 1'b0;
         r_data <= '0;
      end else if (clear) begin
         r_full <= 1'b0;
      end else if (in_valid && !r_full) begin
         r_full <= 1'b1;
         r_data <= in_data;
      end
   end

   assign in_ready = ~r_full;
   assign full     = r_full;
   assign data     = r_data;

endmodule
`default_nettype wire

// File: rtl/axi_lite_io_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_io_slave
// Description : AXI4-Lite responder that serialises single-beat reads and
//               writes onto the internal IO register bus. AW, W and AR are
//               captured independently; one transaction is executed at a time
//               with round-robin arbitration between reads and writes.
// Ports       : clk, reset           - clock, synchronous active-high reset
//               s_axi_aw*/w*/b*      - AXI-Lite write channels
//               s_axi_ar*/r*         - AXI-Lite read channels
//               io_write_en/io_read_en - one-cycle IO strobes
//               io_address           - byte offset inside the decoded window
//               io_write_data        - IO write data
//               io_read_data         - peripheral data, 1 cycle after read strobe
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_io_slave
   import axi_lite_io_slave_pkg::*;
#(
   parameter int          C_S_AXI_ADDR_WIDTH = 32,
   parameter int          C_S_AXI_DATA_WIDTH = 32,
   parameter logic [31:0] BASE_ADDR          = 32'hFFFF0000,
   parameter logic [31:0] ADDR_SPAN          = 32'h00010000
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic [2:0]                      s_axi_awprot,
   input  logic                            s_axi_awvalid,
   output logic                            s_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                            s_axi_wvalid,
   output logic                            s_axi_wready,
   output logic [1:0]                      s_axi_bresp,
   output logic                            s_axi_bvalid,
   input  logic                            s_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [2:0]                      s_axi_arprot,
   input  logic                            s_axi_arvalid,
   output logic                            s_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]                      s_axi_rresp,
   output logic                            s_axi_rvalid,
   input  logic                            s_axi_rready,
   output logic                            io_write_en,
   output logic                            io_read_en,
   output logic [31:0]                     io_address,
   output logic [31:0]                     io_write_data,
   input  logic [31:0]                     io_read_data
);

   localparam int c_aw = C_S_AXI_ADDR_WIDTH;
   localparam int c_dw = C_S_AXI_DATA_WIDTH;
   localparam int c_sw = C_S_AXI_DATA_WIDTH / 8;
   localparam logic [c_aw-1:0] c_base = c_aw'(BASE_ADDR);
   localparam logic [c_aw-1:0] c_span = c_aw'(ADDR_SPAN);

   // Protection bits carry no meaning on the IO bus.
   logic w_unused;
   assign w_unused = ^{s_axi_awprot, s_axi_arprot};

   // ---------------------------------------------------------------- holding
   logic              w_aw_full, w_w_full, w_ar_full;
   logic [c_aw-1:0]   w_aw_addr, w_ar_addr;
   logic [c_sw+c_dw-1:0] w_w_payload;
   logic              w_clr_wr, w_clr_rd;

   axi_lite_hold_reg #(.WIDTH(c_aw)) u_hold_aw (
      .clk(clk), .reset(reset),
      .in_valid(s_axi_awvalid), .in_ready(s_axi_awready), .in_data(s_axi_awaddr),
      .clear(w_clr_wr), .full(w_aw_full), .data(w_aw_addr)
   );

   axi_lite_hold_reg #(.WIDTH(c_sw + c_dw)) u_hold_w (
      .clk(clk), .reset(reset),
      .in_valid(s_axi_wvalid), .in_ready(s_axi_wready), .in_data({s_axi_wstrb, s_axi_wdata}),
      .clear(w_clr_wr), .full(w_w_full), .data(w_w_payload)
   );

   axi_lite_hold_reg #(.WIDTH(c_aw)) u_hold_ar (
      .clk(clk), .reset(reset),
      .in_valid(s_axi_arvalid), .in_ready(s_axi_arready), .in_data(s_axi_araddr),
      .clear(w_clr_rd), .full(w_ar_full), .data(w_ar_addr)
   );

   // ----------------------------------------------------------------- decode
   logic [c_dw-1:0] w_wdata;
   logic [c_sw-1:0] w_wstrb;
   logic [c_aw-1:0] w_aw_off, w_ar_off;
   logic            w_aw_hit, w_ar_hit, w_wr_ok;

   assign w_wdata  = w_w_payload[c_dw-1:0];
   assign w_wstrb  = w_w_payload[c_sw+c_dw-1:c_dw];
   // Wrap-around subtraction makes addresses below the base look huge, so a
   // single unsigned compare covers both window edges.
   assign w_aw_off = w_aw_addr - c_base;
   assign w_ar_off = w_ar_addr - c_base;
   assign w_aw_hit = w_aw_off < c_span;
   assign w_ar_hit = w_ar_off < c_span;
   assign w_wr_ok  = w_aw_hit && (&w_wstrb);

   // ------------------------------------------------------------------- FSM
   slave_state_t    r_state, w_state_nxt;
   logic            r_last_read, w_last_read_nxt;
   logic            r_io_we, w_io_we_nxt, r_io_re, w_io_re_nxt;
   logic [31:0]     r_io_addr, w_io_addr_nxt, r_io_wdata, w_io_wdata_nxt;
   logic            r_bvalid, w_bvalid_nxt, r_rvalid, w_rvalid_nxt;
   axi_resp_t       r_bresp, w_bresp_nxt, r_rresp, w_rresp_nxt;
   logic [c_dw-1:0] r_rdata, w_rdata_nxt;
   logic            w_wr_ready, w_rd_ready;

   assign w_wr_ready = w_aw_full && w_w_full;
   assign w_rd_ready = w_ar_full;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_last_read <= 1'b0;
         r_io_we     <= 1'b0;
         r_io_re     <= 1'b0;
         r_io_addr   <= '0;
         r_io_wdata  <= '0;
         r_bvalid    <= 1'b0;
         r_rvalid    <= 1'b0;
         r_bresp     <= OKAY;
         r_rresp     <= OKAY;
         r_rdata     <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_last_read <= w_last_read_nxt;
         r_io_we     <= w_io_we_nxt;
         r_io_re     <= w_io_re_nxt;
         r_io_addr   <= w_io_addr_nxt;
         r_io_wdata  <= w_io_wdata_nxt;
         r_bvalid    <= w_bvalid_nxt;
         r_rvalid    <= w_rvalid_nxt;
         r_bresp     <= w_bresp_nxt;
         r_rresp     <= w_rresp_nxt;
         r_rdata     <= w_rdata_nxt;
      end
   end

   // The IO strobes are registered on the edge that enters an ISSUE state, so
   // they are high exactly for the ISSUE cycle and default low everywhere else.
   always_comb begin
      w_state_nxt     = r_state;
      w_last_read_nxt = r_last_read;
      w_io_we_nxt     = 1'b0;
      w_io_re_nxt     = 1'b0;
      w_io_addr_nxt   = r_io_addr;
      w_io_wdata_nxt  = r_io_wdata;
      w_bvalid_nxt    = r_bvalid;
      w_rvalid_nxt    = r_rvalid;
      w_bresp_nxt     = r_bresp;
      w_rresp_nxt     = r_rresp;
      w_rdata_nxt     = r_rdata;
      w_clr_wr        = 1'b0;
      w_clr_rd        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // When both directions wait, serve the one not served last.
            if (w_wr_ready && (!w_rd_ready || r_last_read)) begin
               w_state_nxt     = ST_WR_ISSUE;
               w_last_read_nxt = 1'b0;
               w_io_we_nxt     = w_wr_ok;
               w_io_addr_nxt   = 32'(w_aw_off);
               w_io_wdata_nxt  = w_wdata;
            end else if (w_rd_ready) begin
               w_state_nxt     = ST_RD_ISSUE;
               w_last_read_nxt = 1'b1;
               w_io_re_nxt     = w_ar_hit;
               w_io_addr_nxt   = 32'(w_ar_off);
            end
         end
         ST_WR_ISSUE: begin
            w_bresp_nxt  = decode_resp(w_aw_hit, &w_wstrb);
            w_bvalid_nxt = 1'b1;
            w_state_nxt  = ST_B_RESP;
         end
         ST_RD_ISSUE: begin
            w_state_nxt = ST_RD_CAPTURE;
         end
         ST_RD_CAPTURE: begin
            w_rdata_nxt  = w_ar_hit ? io_read_data : '0;
            w_rresp_nxt  = decode_resp(w_ar_hit, 1'b1);
            w_rvalid_nxt = 1'b1;
            w_state_nxt  = ST_R_RESP;
         end
         ST_B_RESP: begin
            if (s_axi_bready) begin
               w_bvalid_nxt = 1'b0;
               w_clr_wr     = 1'b1;
               w_state_nxt  = ST_IDLE;
            end
         end
         ST_R_RESP: begin
            if (s_axi_rready) begin
               w_rvalid_nxt = 1'b0;
               w_clr_rd     = 1'b1;
               w_state_nxt  = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign s_axi_bvalid  = r_bvalid;
   assign s_axi_bresp   = r_bresp;
   assign s_axi_rvalid  = r_rvalid;
   assign s_axi_rresp   = r_rresp;
   assign s_axi_rdata   = r_rdata;
   assign io_write_en   = r_io_we;
   assign io_read_en    = r_io_re;
   assign io_address    = r_io_addr;
   assign io_write_data = r_io_wdata;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_io_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_io_slave
// Description : Scoreboard bench for axi_lite_io_slave. Stimulus tasks drive
//               the AXI channels and push expected B, R and IO-bus events;
//               a monitor pops and compares whenever the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_io_slave;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
   logic [2:0]  s_axi_awprot, s_axi_arprot;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
   logic [1:0]  s_axi_bresp, s_axi_rresp;
   logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
   logic        s_axi_rvalid, s_axi_rready;
   logic        io_write_en, io_read_en;
   logic [31:0] io_address, io_write_data, io_read_data;

   int cyc = 0;
   int n_vec = 0;
   int n_err = 0;

   typedef struct { logic [1:0] resp; logic [31:0] data; int rise; } rsp_t;
   typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; } io_t;
   rsp_t bq[$];
   rsp_t rq[$];
   io_t  ioq[$];

   axi_lite_io_slave dut (
      .clk(clk), .reset(reset),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .io_write_en(io_write_en), .io_read_en(io_read_en),
      .io_address(io_address), .io_write_data(io_write_data),
      .io_read_data(io_read_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic bit in_win(input logic [31:0] a);
      return (a - 32'hFFFF0000) < 32'h00010000;
   endfunction

   function automatic logic [31:0] periph(input logic [31:0] off);
      return (off == 32'h10) ? 32'h12345678 : (32'hA5000000 | off);
   endfunction

   // Peripheral: data valid exactly one cycle after the read strobe, junk otherwise.
   always @(posedge clk)
      io_read_data <= io_read_en ? periph(io_address) : 32'hBAD0BAD0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------------------------------------------------- expectations
   task automatic exp_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int rise);
      rsp_t r;
      io_t  e;
      r.resp = !in_win(a) ? 2'b11 : (s != 4'hF) ? 2'b10 : 2'b00;
      r.data = '0;
      r.rise = rise;
      if (r.resp == 2'b00) begin
         e.wr = 1'b1; e.addr = a - 32'hFFFF0000; e.data = d;
         ioq.push_back(e);
      end
      bq.push_back(r);
   endtask

   task automatic exp_read(input logic [31:0] a, input int rise);
      rsp_t r;
      io_t  e;
      r.rise = rise;
      if (in_win(a)) begin
         e.wr = 1'b0; e.addr = a - 32'hFFFF0000; e.data = '0;
         ioq.push_back(e);
         r.data = periph(e.addr);
         r.resp = 2'b00;
      end else begin
         r.data = '0;
         r.resp = 2'b11;
      end
      rq.push_back(r);
   endtask

   // -------------------------------------------------------------- monitor
   initial begin
      bit b_prev = 0, r_prev = 0, b_hold = 0, r_hold = 0;
      int b_rise = 0, r_rise = 0;
      logic [1:0]  b_hresp = '0, r_hresp = '0;
      logic [31:0] r_hdata = '0;
      rsp_t x;
      io_t  e;
      forever begin
         @(negedge clk);
         if (reset) begin
            b_prev = 0; r_prev = 0; b_hold = 0; r_hold = 0;
         end else begin
            if (b_hold) begin
               check("b_hold_valid", 32'(s_axi_bvalid), 32'd1);
               check("b_hold_resp", 32'(s_axi_bresp), 32'(b_hresp));
            end
            if (r_hold) begin
               check("r_hold_valid", 32'(s_axi_rvalid), 32'd1);
               check("r_hold_data", s_axi_rdata, r_hdata);
               check("r_hold_resp", 32'(s_axi_rresp), 32'(r_hresp));
            end
            if (s_axi_bvalid && !b_prev) b_rise = cyc;
            if (s_axi_rvalid && !r_prev) r_rise = cyc;
            if (io_write_en || io_read_en) begin
               check("io_strobe_exclusive", 32'(io_write_en & io_read_en), 32'd0);
               if (ioq.size() == 0) begin
                  check("io_unexpected_strobe", {io_write_en, io_read_en, io_address[29:0]}, 32'd0);
               end else begin
                  e = ioq.pop_front();
                  check("io_kind_is_write", 32'(io_write_en), 32'(e.wr));
                  check("io_address", io_address, e.addr);
                  if (e.wr) check("io_write_data", io_write_data, e.data);
               end
            end
            if (s_axi_bvalid && s_axi_bready) begin
               if (bq.size() == 0) check("b_unexpected", 32'd1, 32'd0);
               else begin
                  x = bq.pop_front();
                  check("bresp", 32'(s_axi_bresp), 32'(x.resp));
                  if (x.rise >= 0) check("b_latency_cycle", b_rise, x.rise);
               end
            end
            if (s_axi_rvalid && s_axi_rready) begin
               if (rq.size() == 0) check("r_unexpected", 32'd1, 32'd0);
               else begin
                  x = rq.pop_front();
                  check("rdata", s_axi_rdata, x.data);
                  check("rresp", 32'(s_axi_rresp), 32'(x.resp));
                  if (x.rise >= 0) check("r_latency_cycle", r_rise, x.rise);
               end
            end
            b_hold = s_axi_bvalid && !s_axi_bready;
            r_hold = s_axi_rvalid && !s_axi_rready;
            b_hresp = s_axi_bresp;
            r_hresp = s_axi_rresp;
            r_hdata = s_axi_rdata;
            b_prev = s_axi_bvalid;
            r_prev = s_axi_rvalid;
         end
      end
   end

   // ------------------------------------------------------------- drivers
   // All drivers start and end 1 time unit after a rising edge; h returns the
   // edge count at which the handshake happened.
   task automatic send_aw(input logic [31:0] a, output int h);
      bit acc = 0;
      int n = 0;
      s_axi_awaddr = a; s_axi_awvalid = 1'b1;
      while (!acc && n < 50) begin @(posedge clk); acc = s_axi_awready; n++; end
      #1 s_axi_awvalid = 1'b0;
      h = cyc;
      check("aw_accepted", 32'(acc), 32'd1);
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s, output int h);
      bit acc = 0;
      int n = 0;
      s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
      while (!acc && n < 50) begin @(posedge clk); acc = s_axi_wready; n++; end
      #1 s_axi_wvalid = 1'b0;
      h = cyc;
      check("w_accepted", 32'(acc), 32'd1);
   endtask

   task automatic send_ar(input logic [31:0] a, output int h);
      bit acc = 0;
      int n = 0;
      s_axi_araddr = a; s_axi_arvalid = 1'b1;
      while (!acc && n < 50) begin @(posedge clk); acc = s_axi_arready; n++; end
      #1 s_axi_arvalid = 1'b0;
      h = cyc;
      check("ar_accepted", 32'(acc), 32'd1);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int h1, h2;
      fork
         send_aw(a, h1);
         send_w(d, s, h2);
      join
      exp_write(a, d, s, ((h1 > h2) ? h1 : h2) + 2);
   endtask

   task automatic do_read(input logic [31:0] a);
      int h;
      send_ar(a, h);
      exp_read(a, h + 3);
   endtask

   // AR, AW and W offered on the same edge; read_first gives the expected order.
   task automatic pattern(input logic [31:0] ra, input logic [31:0] wa,
                          input logic [31:0] wd, input bit read_first);
      int h1, h2, h3;
      fork
         send_ar(ra, h1);
         send_aw(wa, h2);
         send_w(wd, 4'hF, h3);
      join
      if (read_first) begin exp_read(ra, -1); exp_write(wa, wd, 4'hF, -1); end
      else            begin exp_write(wa, wd, 4'hF, -1); exp_read(ra, -1); end
   endtask

   task automatic wait_rvalid();
      int n = 0;
      while (!s_axi_rvalid && n < 50) begin @(posedge clk); #1; n++; end
      check("rvalid_seen", 32'(s_axi_rvalid), 32'd1);
   endtask

   task automatic drain();
      int n = 0;
      while ((bq.size() != 0 || rq.size() != 0 || ioq.size() != 0 ||
              s_axi_bvalid || s_axi_rvalid) && n < 60) begin
         @(posedge clk); #1; n++;
      end
      check("drain_pending", bq.size() + rq.size() + ioq.size(), 32'd0);
   endtask

   // ------------------------------------------------------------ stimulus
   initial begin
      int h;
      reset = 1'b1;
      s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
      s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
      s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0;
      s_axi_bready = 1'b1; s_axi_rready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      check("rst_awready", 32'(s_axi_awready), 32'd1);
      check("rst_wready", 32'(s_axi_wready), 32'd1);
      check("rst_arready", 32'(s_axi_arready), 32'd1);
      check("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
      check("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
      check("rst_bresp", 32'(s_axi_bresp), 32'd0);
      check("rst_rresp", 32'(s_axi_rresp), 32'd0);
      check("rst_rdata", s_axi_rdata, 32'd0);
      check("rst_io_en", 32'({io_write_en, io_read_en}), 32'd0);

      // Plain write, AW and W together.
      do_write(32'hFFFF0004, 32'hDEADBEEF, 4'hF);
      drain();

      // Read held off by the master for 5 cycles.
      s_axi_rready = 1'b0;
      do_read(32'hFFFF0010);
      wait_rvalid();
      repeat (5) @(posedge clk);
      #1 s_axi_rready = 1'b1;
      drain();

      // W three cycles ahead of AW.
      send_w(32'hCAFEF00D, 4'hF, h);
      repeat (3) @(posedge clk);
      #1;
      send_aw(32'hFFFF0008, h);
      exp_write(32'hFFFF0008, 32'hCAFEF00D, 4'hF, h + 2);
      drain();

      // Read miss, partial-strobe write, write miss.
      do_read(32'h00001000);
      drain();
      do_write(32'hFFFF000C, 32'h00005555, 4'h3);
      drain();
      do_write(32'h00002000, 32'h01020304, 4'hF);
      drain();

      // Arbitration: last served was a write, so reads win.
      pattern(32'hFFFF0030, 32'hFFFF0034, 32'h11112222, 1'b1);
      drain();
      pattern(32'hFFFF0038, 32'hFFFF003C, 32'h33334444, 1'b1);
      drain();
      // After a lone read the write wins.
      do_read(32'hFFFF0040);
      drain();
      pattern(32'hFFFF0050, 32'hFFFF0054, 32'h55556666, 1'b0);
      drain();

      // Reset during R_RESP drops the response.
      s_axi_rready = 1'b0;
      do_read(32'hFFFF0020);
      wait_rvalid();
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      check("mid_rst_rvalid", 32'(s_axi_rvalid), 32'd0);
      check("mid_rst_bvalid", 32'(s_axi_bvalid), 32'd0);
      check("mid_rst_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd7);
      check("mid_rst_rdata", s_axi_rdata, 32'd0);
      rq.delete();
      s_axi_rready = 1'b1;
      do_read(32'hFFFF0024);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
